// File: rtl/mac_pkg.sv
// Shared types and constants for the EX-stage multiply-accumulate sequencer.
package mac_pkg;

  localparam int unsigned MAC_WIDTH = 32;
  localparam int unsigned MAC_CNT_W = $clog2(MAC_WIDTH) + 1;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_MUL  = 2'd1,
    MAC_ACC  = 2'd2,
    MAC_DONE = 2'd3
  } mac_state_e;

  // Width of an iteration counter able to hold the value `width`.
  function automatic int unsigned mac_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Request/response bundle between EX decode and the MAC sequencer.
interface mac_seq_ctrl_if
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_WIDTH
);

  logic             mac_start;
  logic             mac_flush;
  logic [WIDTH-1:0] mac_op_a;
  logic [WIDTH-1:0] mac_op_b;
  logic [WIDTH-1:0] mac_op_c;
  logic             mac_busy;
  logic             mac_stall;
  logic             mac_done;
  logic [WIDTH-1:0] mac_result;
  logic             mac_ovf;

  modport master (
    output mac_start, mac_flush, mac_op_a, mac_op_b, mac_op_c,
    input  mac_busy, mac_stall, mac_done, mac_result, mac_ovf
  );

  modport slave (
    input  mac_start, mac_flush, mac_op_a, mac_op_b, mac_op_c,
    output mac_busy, mac_stall, mac_done, mac_result, mac_ovf
  );

endinterface

// File: rtl/mac_shift_add_dp.sv
// Shift-and-add datapath: operand registers, 2*WIDTH product, final accumulate
// and the held result/overflow registers.
module mac_shift_add_dp
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             acc,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  output logic             last_step_c,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + 1;

  logic [PW-1:0]    a_reg;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;
  logic [SW-1:0]    sum_c;

  // The current step is the last one when the shifted multiplier will be zero.
  assign last_step_c = (b_reg[WIDTH-1:1] == '0);
  assign sum_c       = SW'(prod) + SW'(c_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      c_reg  <= '0;
      prod   <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      if (load) begin
        a_reg <= PW'(op_a);
        b_reg <= op_b;
        c_reg <= op_c;
        prod  <= '0;
      end else if (step) begin
        if (b_reg[0]) begin
          prod <= prod + a_reg;
        end
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
      end
      if (acc) begin
        result <= sum_c[WIDTH-1:0];
        ovf    <= |sum_c[PW:WIDTH];
      end
    end
  end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Multi-cycle A*B+C sequencer for EX: FSM, start/done handshake and pipeline
// stall, driving a shift-and-add datapath with early termination.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH = MAC_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.slave  bus
);

  localparam logic [1:0]  S_IDLE = 2'(MAC_IDLE);
  localparam logic [1:0]  S_MUL  = 2'(MAC_MUL);
  localparam logic [1:0]  S_ACC  = 2'(MAC_ACC);
  localparam logic [1:0]  S_DONE = 2'(MAC_DONE);
  localparam int unsigned CNT_W  = mac_cnt_w(WIDTH);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             accept_c;
  logic             ops_zero_c;
  logic             last_step_c;
  logic             load_c;
  logic             step_c;
  logic             acc_c;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] iter_cnt;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;

  // Next-state and datapath enables; flush overrides every state.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    acc_c      = 1'b0;
    accept_c   = ((state == S_IDLE) || (state == S_DONE)) && !bus.mac_flush;
    ops_zero_c = (bus.mac_op_a == '0) || (bus.mac_op_b == '0);
    if (bus.mac_flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.mac_start) begin
            load_c     = 1'b1;
            state_next = ops_zero_c ? S_ACC : S_MUL;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_MUL: begin
          step_c = 1'b1;
          if (last_step_c) begin
            state_next = S_ACC;
          end
        end
        S_ACC: begin
          acc_c      = 1'b1;
          state_next = S_DONE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iter_cnt <= '0;
    end else begin
      state    <= state_next;
      busy_q   <= (state_next == S_MUL) || (state_next == S_ACC);
      done_q   <= (state_next == S_DONE);
      if (load_c) begin
        iter_cnt <= '0;
      end else if (step_c) begin
        iter_cnt <= iter_cnt + CNT_W'(1);
      end
    end
  end

  // Early termination must never let the multiply run past WIDTH steps.
  assert property (@(posedge clk) disable iff (reset)
                   step_c |-> (iter_cnt < CNT_W'(WIDTH)));

  mac_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .step        (step_c),
    .acc         (acc_c),
    .op_a        (bus.mac_op_a),
    .op_b        (bus.mac_op_b),
    .op_c        (bus.mac_op_c),
    .last_step_c (last_step_c),
    .result      (result_q),
    .ovf         (ovf_q)
  );

  assign bus.mac_busy   = busy_q;
  assign bus.mac_done   = done_q;
  assign bus.mac_result = result_q;
  assign bus.mac_ovf    = ovf_q;
  assign bus.mac_stall  = (bus.mac_start && accept_c) || busy_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl.
module tb_mac_seq_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mac_seq_ctrl_if #(.WIDTH(32)) bus ();

  mac_seq_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation in the current cycle and checks every following cycle
  // up to and including the expected done cycle (start cycle + lat).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input int lat, input logic [31:0] exp_res,
                        input logic exp_ovf, input int pulse_at);
    bus.mac_start = 1'b1;
    bus.mac_op_a  = a;
    bus.mac_op_b  = b;
    bus.mac_op_c  = c;
    #1;
    check({tag, " stall@start"}, 64'(bus.mac_stall), 64'd1);
    tick();
    bus.mac_start = 1'b0;
    for (int j = 1; j <= lat; j++) begin
      bus.mac_op_a  = $urandom;
      bus.mac_op_b  = $urandom;
      bus.mac_op_c  = $urandom;
      bus.mac_start = (j == pulse_at);
      #1;
      check({tag, " done"}, 64'(bus.mac_done), 64'(j == lat));
      check({tag, " stall"}, 64'(bus.mac_stall), 64'(j < lat));
      if (j == lat) begin
        check({tag, " busy@done"}, 64'(bus.mac_busy), 64'd0);
        check({tag, " result"}, 64'(bus.mac_result), 64'(exp_res));
        check({tag, " ovf"}, 64'(bus.mac_ovf), 64'(exp_ovf));
      end else begin
        tick();
        bus.mac_start = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.mac_start = 1'b0;
    bus.mac_flush = 1'b0;
    bus.mac_op_a  = '0;
    bus.mac_op_b  = '0;
    bus.mac_op_c  = '0;

    // Reset with toggling inputs.
    for (int i = 0; i < 2; i++) begin
      bus.mac_start = 1'($urandom);
      bus.mac_flush = 1'($urandom);
      bus.mac_op_a  = $urandom;
      bus.mac_op_b  = $urandom;
      bus.mac_op_c  = $urandom;
      tick();
      check("rst busy", 64'(bus.mac_busy), 64'd0);
      check("rst done", 64'(bus.mac_done), 64'd0);
      check("rst result", 64'(bus.mac_result), 64'd0);
      check("rst ovf", 64'(bus.mac_ovf), 64'd0);
      check("rst state", 64'(dut.state), 64'd0);
    end
    bus.mac_start = 1'b0;
    bus.mac_flush = 1'b0;
    reset = 1'b0;
    tick();
    check("idle stall", 64'(bus.mac_stall), 64'd0);

    run_op("3*5+7", 32'd3, 32'd5, 32'd7, 5, 32'd22, 1'b0, 0);
    tick();
    check("3*5+7 done one-shot", 64'(bus.mac_done), 64'd0);

    run_op("0*100+9", 32'd0, 32'd100, 32'd9, 2, 32'd9, 1'b0, 0);
    tick();
    run_op("100*0+9", 32'd100, 32'd0, 32'd9, 2, 32'd9, 1'b0, 0);
    tick();

    run_op("max*2", 32'hFFFF_FFFF, 32'd2, 32'd0, 4, 32'hFFFF_FFFE, 1'b1, 0);
    tick();
    run_op("1*msb+max", 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h7FFF_FFFF, 1'b1, 0);
    tick();

    // Flush in the second MUL cycle of a long operation.
    bus.mac_start = 1'b1;
    bus.mac_op_a  = 32'd5;
    bus.mac_op_b  = 32'h8000_0000;
    bus.mac_op_c  = 32'd3;
    tick();
    bus.mac_start = 1'b0;
    tick();
    bus.mac_flush = 1'b1;
    #1;
    check("flush stall", 64'(bus.mac_stall), 64'd1);
    tick();
    bus.mac_flush = 1'b0;
    #1;
    check("flush state", 64'(dut.state), 64'd0);
    check("flush busy", 64'(bus.mac_busy), 64'd0);
    check("flush done", 64'(bus.mac_done), 64'd0);
    check("flush result kept", 64'(bus.mac_result), 64'h7FFF_FFFF);
    check("flush ovf kept", 64'(bus.mac_ovf), 64'd1);
    run_op("post-flush 2*2+1", 32'd2, 32'd2, 32'd1, 4, 32'd5, 1'b0, 0);
    tick();

    // Flush and start together: the start is dropped.
    bus.mac_start = 1'b1;
    bus.mac_flush = 1'b1;
    bus.mac_op_a  = 32'd9;
    bus.mac_op_b  = 32'd9;
    bus.mac_op_c  = 32'd9;
    #1;
    check("flush+start stall", 64'(bus.mac_stall), 64'd0);
    tick();
    bus.mac_start = 1'b0;
    bus.mac_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("flush+start busy", 64'(bus.mac_busy), 64'd0);
      check("flush+start done", 64'(bus.mac_done), 64'd0);
      tick();
    end
    check("flush+start result kept", 64'(bus.mac_result), 64'd5);

    // Start pulsed during MUL is ignored.
    run_op("mul-pulse 1*16", 32'd1, 32'h10, 32'd0, 7, 32'h10, 1'b0, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mul-pulse no 2nd done", 64'(bus.mac_done), 64'd0);
    end

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op("b2b first 6*7+1", 32'd6, 32'd7, 32'd1, 5, 32'd43, 1'b0, 0);
    run_op("b2b second 4*3+2", 32'd4, 32'd3, 32'd2, 4, 32'd14, 1'b0, 0);
    tick();
    check("b2b done one-shot", 64'(bus.mac_done), 64'd0);
    check("b2b idle", 64'(dut.state), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage multiply-accumulate operation: result = A*B + C.
- Built as a clocked shift-and-add engine with early termination, plus a start/done handshake and a pipeline stall output.
- Sits beside the ALU in EX. The hazard unit ORs mac_stall into the global stall. The EX/MEM mux takes mac_result when mac_done is high.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mac_start  input  1  request from EX decode; operands valid in the same cycle.
- mac_flush  input  1  pipeline flush; aborts any operation in flight.
- mac_op_a  input  WIDTH  multiplicand A, unsigned.
- mac_op_b  input  WIDTH  multiplier B, unsigned.
- mac_op_c  input  WIDTH  addend C, unsigned.
- mac_busy  output  1  high in MUL and ACC states.
- mac_stall  output  1  combinational: (mac_start & accept) | mac_busy.
- mac_done  output  1  one-cycle pulse; mac_result is valid in this cycle.
- mac_result  output  WIDTH  low WIDTH bits of A*B+C; held until the next completion.
- mac_ovf  output  1  set if the true A*B+C does not fit in WIDTH bits; held with mac_result.

Behaviour:
- Reset (synchronous) takes priority over everything:
  - state=IDLE; mac_busy=0, mac_done=0, mac_result=0, mac_ovf=0.
  - Internal registers are cleared.
  - Reset asserted mid-operation discards the operation.
- States: IDLE, MUL, ACC, DONE.
- accept = (state==IDLE or state==DONE) & ~mac_flush.
- IDLE/DONE with mac_start & accept:
  - Latch a_reg (2*WIDTH, zero-extended A), b_reg=B, c_reg=C, prod=0.
  - Next state is ACC if A==0 or B==0, else MUL.
  - Without a start, DONE returns to IDLE.
- MUL, one multiplier bit per cycle:
  - If b_reg[0], prod += a_reg.
  - Then a_reg <<= 1 and b_reg >>= 1.
  - Leave to ACC after the cycle in which the shifted b_reg becomes 0.
  - MUL cycle count k = index of the most-significant set bit of B, plus 1 (1..WIDTH).
- ACC, one cycle:
  - sum = prod + c_reg, computed at 2*WIDTH+1 bits.
  - mac_result <= sum[WIDTH-1:0].
  - mac_ovf <= |sum[2*WIDTH:WIDTH].
  - Next state DONE.
- DONE: mac_done=1 for exactly this cycle; mac_busy=0, so the pipeline advances with the result.
- Latency: with start sampled in cycle N, mac_done is high in cycle N+k+2.
  - Zero-operand path (k=0): done in cycle N+2.
  - Worst case (B MSB set): done in cycle N+WIDTH+2.
- mac_start while in MUL or ACC is ignored. The requester is held by mac_stall, so no request is lost.
- Back-to-back: a start in DONE is accepted in the same cycle that mac_done is high.
- mac_flush:
  - In any state except reset, next state is IDLE.
  - No mac_done is issued; mac_result and mac_ovf keep their previous values.
  - Flush and start in the same cycle: flush wins and the start is dropped.
- Arithmetic is unsigned and modulo 2^WIDTH for the result. The internal product is 2*WIDTH bits, so nothing is lost before the overflow evaluation.
- No combinational path from operands to outputs. The only combinational path from mac_start/mac_flush is to mac_stall.

Decomposition:
- Package mac_pkg:
  - State enum (IDLE, MUL, ACC, DONE).
  - MAC_WIDTH default constant.
  - MAC_CNT_W = clog2(WIDTH)+1, for the optional iteration counter used by assertions.
- One natural sub-module: mac_shift_add_dp. It holds a_reg, b_reg, c_reg, prod and the add/shift/accumulate logic, with load/step/acc enables.
- mac_seq_ctrl keeps the FSM, the handshake and the stall logic.

Test Plan:
- Reset held 2 cycles with random inputs toggling -> mac_busy=0, mac_done=0, mac_result=0, mac_ovf=0; state IDLE.
- A=3, B=5, C=7, start in cycle N -> mac_stall high N..N+4, mac_done only in N+5 (k=3), mac_result=22, mac_ovf=0.
- A=0, B=100, C=9 -> done in N+2, result=9, ovf=0. Repeat with A=100, B=0 -> same result and timing.
- A=0xFFFF_FFFF, B=2, C=0 -> done in N+4, result=0xFFFF_FFFE, ovf=1.
- A=1, B=0x8000_0000, C=0xFFFF_FFFF -> done in N+34, result=0x7FFF_FFFF, ovf=1.
- Flush during MUL, cycle N+2 of a B=0x8000_0000 operation:
  - No mac_done; state IDLE in N+3; result and ovf unchanged.
  - A start in N+3 with A=2, B=2, C=1 -> done in N+7, result=5.
- Start pulsed during MUL -> ignored, no second done.
- Back-to-back: start held in the DONE cycle -> second operation accepted, its done follows after the correct latency.
